// File: rtl/temp_pkg.sv
// temp_pkg: shared types, glyph codes and 14-segment patterns for temp_status_display.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package temp_pkg;

   // Number of time-multiplexed display digits (d4..d0).
   localparam int NUM_DIGITS = 5;

   typedef enum logic [1:0] {
      COLD   = 2'b00,
      NORMAL = 2'b01,
      HOT    = 2'b10
   } status_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CONV   = 2'b01,
      COMMIT = 2'b10
   } conv_state_e;

   // 4-bit glyph codes held in the digit registers. Codes 0..9 are the decimal digits.
   localparam logic [3:0] GC_C     = 4'd10;
   localparam logic [3:0] GC_N     = 4'd11;
   localparam logic [3:0] GC_H     = 4'd12;
   localparam logic [3:0] GC_DASH  = 4'd13;
   localparam logic [3:0] GC_BLANK = 4'd15;

   // Segment order {a,b,c,d,e,f,g1,g2,h,i,j,k,l,m}, MSB first. The N diagonal uses h and m.
   localparam logic [13:0] SEG_0     = 14'h3F00;
   localparam logic [13:0] SEG_1     = 14'h1800;
   localparam logic [13:0] SEG_2     = 14'h36C0;
   localparam logic [13:0] SEG_3     = 14'h3CC0;
   localparam logic [13:0] SEG_4     = 14'h19C0;
   localparam logic [13:0] SEG_5     = 14'h2DC0;
   localparam logic [13:0] SEG_6     = 14'h2FC0;
   localparam logic [13:0] SEG_7     = 14'h3800;
   localparam logic [13:0] SEG_8     = 14'h3FC0;
   localparam logic [13:0] SEG_9     = 14'h3DC0;
   localparam logic [13:0] SEG_C     = 14'h2700;
   localparam logic [13:0] SEG_N     = 14'h1B21;
   localparam logic [13:0] SEG_H     = 14'h1BC0;
   localparam logic [13:0] SEG_DASH  = 14'h00C0;
   localparam logic [13:0] SEG_BLANK = 14'h0000;

   // One double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   function automatic logic [11:0] dabble_adj(input logic [11:0] bcd);
      logic [11:0] r;
      r = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Hysteretic classifier; all operands are 10-bit signed so thresholds never wrap.
   function automatic status_e next_status(input status_e            cur,
                                           input logic signed [9:0] t,
                                           input logic signed [9:0] cold_th,
                                           input logic signed [9:0] hot_th,
                                           input logic signed [9:0] hot_exit,
                                           input logic signed [9:0] cold_exit);
      status_e r;
      r = cur;
      case (cur)
         NORMAL: begin
            if (t >= hot_th)       r = HOT;
            else if (t <= cold_th) r = COLD;
         end
         HOT: begin
            if (t <= cold_th)       r = COLD;
            else if (t < hot_exit)  r = NORMAL;
         end
         COLD: begin
            if (t >= hot_th)        r = HOT;
            else if (t > cold_exit) r = NORMAL;
         end
         default: r = NORMAL;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] status_glyph(input status_e s);
      logic [3:0] g;
      case (s)
         COLD:    g = GC_C;
         HOT:     g = GC_H;
         default: g = GC_N;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg14_encode.sv
// seg14_encode: maps a 4-bit glyph code to its 14-segment pattern.
// Latency: combinational.
// Backpressure: none.
// Ports: code (glyph code in), seg (segment bits {a..m} out, active high).
module seg14_encode
   import temp_pkg::*;
(
   input  logic [3:0]  code,
   output logic [13:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         GC_C:    seg = SEG_C;
         GC_N:    seg = SEG_N;
         GC_H:    seg = SEG_H;
         GC_DASH: seg = SEG_DASH;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/temp_status_display.sv
// temp_status_display: classifies each averaged temperature (COLD/NORMAL/HOT with hysteresis),
// converts it to decimal and scans it onto a 5-digit 14-segment display.
// Latency: 9 cycles strobe-to-display; backpressure: none, one-deep pending slot, last strobe wins.
// Ports: clk_i, rst_ni (async active-low), avg_i/avg_valid_i (sample strobe), busy_o,
//        status_o (00 COLD, 01 NORMAL, 10 HOT), seg_o {a..m}, digit_sel_o (one-hot, bit i = d_i).
// Optional macro STATUS_BLINK_EN: blanks seg_o on alternate BLINK_FRAMES-frame periods while HOT.
module temp_status_display
   import temp_pkg::*;
#(
   parameter int          SCAN_DIV     = 1000,
   parameter int          COLD_TH      = 5,
   parameter int          HOT_TH       = 30,
   parameter int unsigned HYST         = 2,
   parameter int          BLINK_FRAMES = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  avg_i,
   input  logic        avg_valid_i,
   output logic        busy_o,
   output logic [1:0]  status_o,
   output logic [13:0] seg_o,
   output logic [4:0]  digit_sel_o
);

   localparam int SCAN_W = $clog2(SCAN_DIV);

   localparam logic signed [9:0] COLD_LIM  = 10'(COLD_TH);
   localparam logic signed [9:0] HOT_LIM   = 10'(HOT_TH);
   localparam logic signed [9:0] HOT_EXIT  = 10'(HOT_TH - int'(HYST));
   localparam logic signed [9:0] COLD_EXIT = 10'(COLD_TH + int'(HYST));

   // Out-of-range configurations (SCAN_DIV < 2, BLINK_FRAMES < 1, HYST > 15) are not supported.
   if (SCAN_DIV < 2 || BLINK_FRAMES < 1 || HYST > 15) begin : g_bad_params
   end

   // ---------------------------------------------------------------- converter FSM
   conv_state_e state_q, state_d;
   logic        load, iter_step, commit;

   logic [7:0]  sample_q;
   logic [11:0] bcd_q;
   logic [7:0]  bin_q;
   logic [2:0]  iter_q;
   logic        pend_vld_q;
   logic [7:0]  pend_dat_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      iter_step = 1'b0;
      commit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (avg_valid_i) begin
               state_d = CONV;
               load    = 1'b1;
            end
         end
         CONV: begin
            iter_step = 1'b1;
            if (iter_q == 3'd7) state_d = COMMIT;
         end
         COMMIT: begin
            commit = 1'b1;
            // A strobe on the commit cycle supersedes the slot (last value wins).
            if (avg_valid_i || pend_vld_q) begin
               state_d = CONV;
               load    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q != IDLE);

   // ---------------------------------------------------------------- pending slot
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_vld_q <= 1'b0;
         pend_dat_q <= '0;
      end else if (state_q == CONV && avg_valid_i) begin
         pend_vld_q <= 1'b1;
         pend_dat_q <= avg_i;
      end else if (commit) begin
         pend_vld_q <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- double dabble
   logic [7:0] load_dat;
   logic [8:0] load_ext, load_mag;

   assign load_dat = avg_valid_i ? avg_i : pend_dat_q;
   assign load_ext = {load_dat[7], load_dat};
   assign load_mag = load_dat[7] ? (~load_ext + 9'd1) : load_ext;

   // The magnitude is 9 bits but only 8 iterations run: the first adjust of an all-zero BCD
   // register is a no-op, so the MSB is shifted straight into BCD bit 0 at capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sample_q <= '0;
         bcd_q    <= '0;
         bin_q    <= '0;
         iter_q   <= '0;
      end else if (load) begin
         sample_q <= load_dat;
         bcd_q    <= {11'd0, load_mag[8]};
         bin_q    <= load_mag[7:0];
         iter_q   <= '0;
      end else if (iter_step) begin
         {bcd_q, bin_q} <= {dabble_adj(bcd_q), bin_q} << 1;
         iter_q         <= iter_q + 3'd1;
      end
   end

   // ---------------------------------------------------------------- commit: status + digits
   status_e                         status_q, status_nxt;
   logic    [NUM_DIGITS-1:0][3:0]   digit_q;
   logic signed [9:0]               t_ext;
   logic    [3:0]                   hund, tens, ones;

   assign t_ext      = {{2{sample_q[7]}}, sample_q};
   assign status_nxt = next_status(status_q, t_ext, COLD_LIM, HOT_LIM, HOT_EXIT, COLD_EXIT);
   assign hund       = bcd_q[11:8];
   assign tens       = bcd_q[7:4];
   assign ones       = bcd_q[3:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         status_q <= NORMAL;
         digit_q  <= {NUM_DIGITS{GC_BLANK}};
      end else if (commit) begin
         status_q   <= status_nxt;
         digit_q[4] <= status_glyph(status_nxt);
         digit_q[3] <= sample_q[7] ? GC_DASH : GC_BLANK;
         digit_q[2] <= (hund == 4'd0) ? GC_BLANK : hund;
         digit_q[1] <= (hund == 4'd0 && tens == 4'd0) ? GC_BLANK : tens;
         digit_q[0] <= ones;
      end
   end

   assign status_o = status_q;

   // ---------------------------------------------------------------- scanner
   logic [SCAN_W-1:0] presc_q;
   logic [2:0]        idx_q, idx_d;
   logic              scan_tc;
   logic [3:0]        sel_code;
   logic [13:0]       sel_seg, seg_q;
   logic [4:0]        digit_sel_q;

   assign scan_tc = (presc_q == SCAN_W'(SCAN_DIV - 1));

   always_comb begin
      idx_d = idx_q;
      if (scan_tc) idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
   end

   // Glyph is looked up from the next index so seg_o and digit_sel_o switch on the same edge.
   always_comb begin
      sel_code = GC_BLANK;
      case (idx_d)
         3'd0:    sel_code = digit_q[0];
         3'd1:    sel_code = digit_q[1];
         3'd2:    sel_code = digit_q[2];
         3'd3:    sel_code = digit_q[3];
         3'd4:    sel_code = digit_q[4];
         default: sel_code = GC_BLANK;
      endcase
   end

   seg14_encode u_seg14_encode (
      .code (sel_code),
      .seg  (sel_seg)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q     <= '0;
         idx_q       <= '0;
         digit_sel_q <= 5'b00001;
         seg_q       <= '0;
      end else begin
         presc_q     <= scan_tc ? '0 : presc_q + SCAN_W'(1);
         idx_q       <= idx_d;
         digit_sel_q <= 5'b00001 << idx_d;
         seg_q       <= sel_seg;
      end
   end

   assign digit_sel_o = digit_sel_q;

   // ---------------------------------------------------------------- optional HOT blink
`ifdef STATUS_BLINK_EN
   localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BF_W-1:0] frame_cnt_q;
   logic            blink_on_q;
   logic            frame_end;

   assign frame_end = scan_tc && (idx_q == 3'd4);

   // Held at "on" outside HOT so each HOT episode starts visible and leaving HOT unmasks at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (status_q != HOT) begin
         frame_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (frame_end) begin
         if (frame_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
         end else begin
            frame_cnt_q <= frame_cnt_q + BF_W'(1);
         end
      end
   end

   assign seg_o = (status_q == HOT && !blink_on_q) ? 14'd0 : seg_q;
`else
   assign seg_o = seg_q;
`endif

endmodule

// File: tb/tb_temp_status_display.sv
`timescale 1ns/1ps
module tb_temp_status_display;

   logic        clk;
   logic        rst_n;
   logic [7:0]  avg;
   logic        avg_vld;
   logic        busy;
   logic [1:0]  status;
   logic [13:0] seg;
   logic [4:0]  sel;

   int checks   = 0;
   int failures = 0;

   localparam logic [3:0] C_ = 4'd10;
   localparam logic [3:0] N_ = 4'd11;
   localparam logic [3:0] H_ = 4'd12;
   localparam logic [3:0] M_ = 4'd13;
   localparam logic [3:0] B_ = 4'd15;

   typedef struct {
      logic [7:0]  v;
      logic [1:0]  st;
      logic [19:0] dig;   // d4..d3..d0 glyph codes
   } vec_t;

   vec_t vecs[$];

   temp_status_display #(
      .SCAN_DIV     (4),
      .COLD_TH      (5),
      .HOT_TH       (30),
      .HYST         (2),
      .BLINK_FRAMES (1)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .avg_i       (avg),
      .avg_valid_i (avg_vld),
      .busy_o      (busy),
      .status_o    (status),
      .seg_o       (seg),
      .digit_sel_o (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference 14-segment font {a,b,c,d,e,f,g1,g2,h,i,j,k,l,m}.
   function automatic logic [13:0] glyph(input logic [3:0] c);
      logic [13:0] g;
      case (c)
         4'd0:  g = 14'b111111_00_000000;
         4'd1:  g = 14'b011000_00_000000;
         4'd2:  g = 14'b110110_11_000000;
         4'd3:  g = 14'b111100_11_000000;
         4'd4:  g = 14'b011001_11_000000;
         4'd5:  g = 14'b101101_11_000000;
         4'd6:  g = 14'b101111_11_000000;
         4'd7:  g = 14'b111000_00_000000;
         4'd8:  g = 14'b111111_11_000000;
         4'd9:  g = 14'b111101_11_000000;
         4'd10: g = 14'b100111_00_000000;
         4'd11: g = 14'b011011_00_100001;
         4'd12: g = 14'b011011_11_000000;
         4'd13: g = 14'b000000_11_000000;
         default: g = 14'd0;
      endcase
      return g;
   endfunction

   function automatic logic [69:0] disp_of(input logic [19:0] d);
      return {glyph(d[19:16]), glyph(d[15:12]), glyph(d[11:8]), glyph(d[7:4]), glyph(d[3:0])};
   endfunction

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Accumulates seg per selected digit over two full scan frames.
   task automatic read_display(output logic [69:0] g);
      logic [4:0][13:0] acc;
      acc = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         for (int i = 0; i < 5; i++) begin
            if (sel == 5'(1 << i)) acc[i] = acc[i] | seg;
         end
      end
      g = acc;
   endtask

   // Returns at the first negedge after digit_sel switches to s.
   task automatic wait_sel(input logic [4:0] s, output logic ok);
      logic [4:0] prev;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         prev = sel;
         @(negedge clk);
         if (sel == s && prev != s) ok = 1'b1;
      end
   endtask

   task automatic apply(input logic [7:0] v, output int cyc);
      avg     = v;
      avg_vld = 1'b1;
      @(negedge clk);
      avg_vld = 1'b0;
      cyc = 0;
      while (busy && cyc < 30) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [69:0] g;
      logic        ok;
      int          cyc;

      rst_n   = 1'b0;
      avg     = 8'd0;
      avg_vld = 1'b0;

      vecs.push_back('{8'd25,  2'b01, {N_, B_, B_, 4'd2, 4'd5}});
      vecs.push_back('{8'h80,  2'b00, {C_, M_, 4'd1, 4'd2, 4'd8}});
      vecs.push_back('{8'd30,  2'b10, {H_, B_, B_, 4'd3, 4'd0}});
      vecs.push_back('{8'd29,  2'b10, {H_, B_, B_, 4'd2, 4'd9}});
      vecs.push_back('{8'd27,  2'b01, {N_, B_, B_, 4'd2, 4'd7}});
      vecs.push_back('{8'd28,  2'b01, {N_, B_, B_, 4'd2, 4'd8}});
      vecs.push_back('{8'd4,   2'b00, {C_, B_, B_, B_, 4'd4}});
      vecs.push_back('{8'd7,   2'b00, {C_, B_, B_, B_, 4'd7}});
      vecs.push_back('{8'd8,   2'b01, {N_, B_, B_, B_, 4'd8}});
      vecs.push_back('{8'd127, 2'b10, {H_, B_, 4'd1, 4'd2, 4'd7}});
      vecs.push_back('{8'd5,   2'b00, {C_, B_, B_, B_, 4'd5}});
      vecs.push_back('{8'd0,   2'b00, {C_, B_, B_, B_, 4'd0}});
      vecs.push_back('{8'hF9,  2'b00, {C_, M_, B_, B_, 4'd7}});
      vecs.push_back('{8'd100, 2'b10, {H_, B_, 4'd1, 4'd0, 4'd0}});
      vecs.push_back('{8'd6,   2'b01, {N_, B_, B_, B_, 4'd6}});

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_busy",   70'(busy),   70'(1'b0));
      chk("rst_status", 70'(status), 70'(2'b01));
      chk("rst_sel",    70'(sel),    70'(5'b00001));
      chk("rst_seg",    70'(seg),    70'(14'd0));
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven conversions (hysteresis state carries from row to row).
      foreach (vecs[i]) begin
         apply(vecs[i].v, cyc);
         chk($sformatf("busy_len[%0d]", i), 70'(cyc), 70'(9));
         chk($sformatf("status[%0d]", i), 70'(status), 70'(vecs[i].st));
         read_display(g);
         chk($sformatf("digits[%0d]", i), g, disp_of(vecs[i].dig));
      end

      // Scan order and per-digit glyph with display N,_,_,_,6.
      wait_sel(5'b00001, ok);
      chk("scan_align", 70'(ok), 70'(1'b1));
      for (int k = 0; k < 24; k++) begin
         logic [19:0] d;
         int          di;
         d  = {N_, B_, B_, B_, 4'd6};
         di = (k / 4) % 5;
         chk($sformatf("scan[%0d]", k), {42'd0, sel, seg, 9'd0},
             {42'd0, 5'(1 << di), glyph(d[di*4 +: 4]), 9'd0});
         @(negedge clk);
      end

      // Pending slot: strobes 10, 20, 40 at cycles 0, 3, 5; align so the tens digit is
      // scanned just after the first commit.
      wait_sel(5'b00010, ok);
      chk("pend_align", 70'(ok), 70'(1'b1));
      repeat (9) @(negedge clk);
      avg = 8'd10; avg_vld = 1'b1;
      @(negedge clk);                       // after N
      avg_vld = 1'b0;
      repeat (2) @(negedge clk);            // after N+2
      avg = 8'd20; avg_vld = 1'b1;
      @(negedge clk);                       // after N+3
      avg_vld = 1'b0;
      @(negedge clk);                       // after N+4
      avg = 8'd40; avg_vld = 1'b1;
      @(negedge clk);                       // after N+5
      avg_vld = 1'b0;
      repeat (4) @(negedge clk);            // after N+9
      chk("pend_status9", 70'(status), 70'(2'b01));
      chk("pend_busy9",   70'(busy),   70'(1'b1));
      repeat (2) @(negedge clk);            // after N+11
      chk("pend_tens9", 70'({sel, seg}), 70'({5'b00010, glyph(4'd1)}));
      repeat (6) @(negedge clk);            // after N+17
      chk("pend_busy17", 70'(busy), 70'(1'b1));
      @(negedge clk);                       // after N+18
      chk("pend_busy18",   70'(busy),   70'(1'b0));
      chk("pend_status18", 70'(status), 70'(2'b10));
      read_display(g);
      chk("pend_digits18", g, disp_of({H_, B_, B_, 4'd4, 4'd0}));

      // Reset in the middle of a conversion of 3 (which would have committed COLD).
      avg = 8'd3; avg_vld = 1'b1;
      @(negedge clk);
      avg_vld = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy_pre", 70'(busy), 70'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("mid_busy",   70'(busy),   70'(1'b0));
      chk("mid_status", 70'(status), 70'(2'b01));
      chk("mid_sel",    70'(sel),    70'(5'b00001));
      chk("mid_seg",    70'(seg),    70'(14'd0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("mid_busy_post",   70'(busy),   70'(1'b0));
      chk("mid_status_post", 70'(status), 70'(2'b01));
      read_display(g);
      chk("mid_digits_post", g, 70'd0);

`ifdef STATUS_BLINK_EN
      begin
         logic [13:0] f1, f2, f3, full;
         full = glyph(H_) | glyph(4'd3) | glyph(4'd5);
         apply(8'd35, cyc);
         chk("blink_status", 70'(status), 70'(2'b10));
         wait_sel(5'b00001, ok);
         chk("blink_align", 70'(ok), 70'(1'b1));
         f1 = '0; f2 = '0; f3 = '0;
         for (int k = 0; k < 20; k++) begin f1 = f1 | seg; @(negedge clk); end
         for (int k = 0; k < 20; k++) begin f2 = f2 | seg; @(negedge clk); end
         for (int k = 0; k < 20; k++) begin f3 = f3 | seg; @(negedge clk); end
         chk("blink_f1f2", 70'(f1 ^ f2), 70'(full));
         chk("blink_f2f3", 70'(f2 ^ f3), 70'(full));
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
